axil_slave_regfile: RTL and testbench
=====================================

Name: axil_slave_regfile

Overview:
- AXI4-Lite responder with an NUM_REGS x 32-bit register file; the slave end of the interface driven by axi_lite_master.
- Used as a standalone target for master bring-up and as a memory-mapped config/scratch block alongside the AXI-APB path.
- Write and read channels run as independent FSMs, with one outstanding transaction per direction.

Parameters:
- ADDR_W, 8, address width in bits (byte address; word index = addr[ADDR_W-1:2]).
- NUM_REGS, 16, number of 32-bit registers; must be ≤ 2^(ADDR_W-2).

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables (bit i covers wdata[8i+7:8i])
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response (00 OKAY, 10 SLVERR)
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- reg_out  out  NUM_REGS*32  flat register contents; reg i is at [32i+31:32i]
- wr_pulse  out  NUM_REGS  per-register write strobe (exists only under the macro)

Behaviour:
- Reset (async, any state): all registers = 0; bvalid = rvalid = 0; bresp = rresp = 00; rdata = 0; both FSMs go to IDLE; any pending response is dropped.
- Write FSM states: WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP. All outputs are decoded from registered state.
  - WR_IDLE: awready = wready = 1.
    - AW and W handshake in the same cycle: commit at that edge, go to WR_RESP.
    - AW only: latch awaddr, go to WR_WAIT_W.
    - W only: latch wdata and wstrb, go to WR_WAIT_AW.
  - WR_WAIT_W: awready = 0, wready = 1. On the W handshake, commit using the latched address, go to WR_RESP.
  - WR_WAIT_AW: awready = 1, wready = 0. On the AW handshake, commit using the latched data, go to WR_RESP.
  - WR_RESP: awready = wready = 0, bvalid = 1, bresp held stable. On bready, go to WR_IDLE (bvalid = 0 next cycle).
  - Commit: for each byte with wstrb[i] = 1, register byte i takes the wdata byte; other bytes hold.
    - wstrb = 0000 still completes with OKAY and changes nothing.
    - Word index ≥ NUM_REGS: nothing is written, bresp = 10.
  - Latency: bvalid rises 1 cycle after the completing handshake edge.
- Read FSM states: RD_IDLE, RD_RESP.
  - RD_IDLE: arready = 1. On the AR handshake, register rdata/rresp from the addressed register at that edge, go to RD_RESP.
  - RD_RESP: arready = 0, rvalid = 1, rdata and rresp held stable until rready, then go to RD_IDLE.
  - Out-of-range index: rdata = 0, rresp = 10.
  - Latency: rvalid rises 1 cycle after the AR handshake.
- Address bits [1:0] are ignored; no unaligned handling.
- Simultaneous read and write commit to the same register on one edge: the read returns the old value. A read issued after the commit edge returns the new value.
- reg_out reflects the register contents directly; an update is visible the cycle after commit.
- Back-to-back transactions: the next AW/W/AR is accepted at the earliest in the cycle after the response handshake (no overlap).

Optional Feature:
- Macro: AXIL_SLV_WR_PULSE_EN.
- Defined: wr_pulse port exists. wr_pulse[idx] = 1 for exactly one cycle, coinciding with the first bvalid cycle of an in-range write with wstrb ≠ 0000. All other bits are 0, and all bits reset to 0.
- Undefined: wr_pulse port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then AW+W together at addr 0x04, wdata 0xDEADBEEF, wstrb 1111, bready = 1 → bvalid 1 cycle later, bresp = 00; reg_out[63:32] = 0xDEADBEEF; a read of 0x04 returns 0xDEADBEEF with rresp = 00 and rvalid 1 cycle after AR.
- W sent 3 cycles before AW (addr 0x08, 0x11223344): wready drops after W, awready stays 1 → reg 2 = 0x11223344. Repeat with AW before W → same result.
- Byte strobe: reg 2 = 0x11223344, write 0xAABBCCDD with wstrb 0101 → reg 2 = 0x11BB33DD.
- Out-of-range with NUM_REGS = 16: write 0x40 → bresp = 10 and no register changes. Read 0x40 → rdata = 0, rresp = 10.
- Backpressure: hold bready = 0 and rready = 0 for 5 cycles → bvalid/rvalid, bresp/rresp, rdata held stable; awready = wready = arready = 0 throughout; a new AW/AR is accepted only after the ready handshake.
- Assert areset_n = 0 while in WR_RESP and RD_RESP → bvalid = rvalid = 0 immediately, all registers = 0. With AXIL_SLV_WR_PULSE_EN defined: a write to reg 3 gives wr_pulse = 0x0008 for exactly 1 cycle.

Source files
------------

// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI4-Lite slave with NUM_REGS x 32-bit register file and independent write/read FSMs.
// Optional per-register write pulse output enabled by defining AXIL_SLV_WR_PULSE_EN.
module axil_slave_regfile #(
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ADDR_W-1:0]      araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [NUM_REGS*32-1:0] reg_out
`ifdef AXIL_SLV_WR_PULSE_EN
    ,output logic [NUM_REGS-1:0]   wr_pulse
`endif
);
    localparam int IW = ADDR_W - 2;
    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
    wr_state_e wr_q, wr_d;
    rd_state_e rd_q, rd_d;
    logic [IW-1:0] awidx_q, widx, ridx;
    logic [31:0]   wdata_q, cdata, rdata_q, rd_word;
    logic [3:0]    wstrb_q, cstrb;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   regs_q [NUM_REGS];
    logic          aw_hs, w_hs, ar_hs, commit, w_in, r_in;
    logic          unused_lsbs;
    assign unused_lsbs = ^{awaddr[1:0], araddr[1:0]};
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_q <= WR_IDLE;
            rd_q <= RD_IDLE;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_comb begin
        wr_d = wr_q;
        case (wr_q)
            WR_IDLE:    wr_d = (aw_hs && w_hs) ? WR_RESP : aw_hs ? WR_WAIT_W : w_hs ? WR_WAIT_AW : WR_IDLE;
            WR_WAIT_W:  wr_d = w_hs ? WR_RESP : WR_WAIT_W;
            WR_WAIT_AW: wr_d = aw_hs ? WR_RESP : WR_WAIT_AW;
            default:    wr_d = bready ? WR_IDLE : WR_RESP;
        endcase
        rd_d = (rd_q == RD_IDLE) ? (ar_hs ? RD_RESP : RD_IDLE) : (rready ? RD_IDLE : RD_RESP);
    end
    assign awready = wr_q == WR_IDLE || wr_q == WR_WAIT_AW;
    assign wready  = wr_q == WR_IDLE || wr_q == WR_WAIT_W;
    assign bvalid  = wr_q == WR_RESP;
    assign bresp   = bresp_q;
    assign arready = rd_q == RD_IDLE;
    assign rvalid  = rd_q == RD_RESP;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (wr_q == WR_IDLE && aw_hs && w_hs) || (wr_q == WR_WAIT_W && w_hs) || (wr_q == WR_WAIT_AW && aw_hs);
    // The half that arrived first comes from the latch, the completing half straight from the bus.
    assign widx  = wr_q == WR_WAIT_W ? awidx_q : awaddr[ADDR_W-1:2];
    assign cdata = wr_q == WR_WAIT_AW ? wdata_q : wdata;
    assign cstrb = wr_q == WR_WAIT_AW ? wstrb_q : wstrb;
    assign ridx  = araddr[ADDR_W-1:2];
    assign w_in  = {1'b0, widx} < (IW+1)'(NUM_REGS);
    assign r_in  = {1'b0, ridx} < (IW+1)'(NUM_REGS);
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (ridx == IW'(r)) rd_word = regs_q[r];
            reg_out[32*r +: 32] = regs_q[r];
        end
    end
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            if (wr_q == WR_IDLE && aw_hs && !w_hs) awidx_q <= awaddr[ADDR_W-1:2];
            if (wr_q == WR_IDLE && w_hs && !aw_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) bresp_q <= w_in ? 2'b00 : 2'b10;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= r_in ? 2'b00 : 2'b10;
            end
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < 4; b++)
                    if (commit && widx == IW'(r) && cstrb[b]) regs_q[r][8*b +: 8] <= cdata[8*b +: 8];
        end
    end
`ifdef AXIL_SLV_WR_PULSE_EN
    logic [NUM_REGS-1:0] pulse_q;
    // Registered at the commit edge, so it lines up with the first bvalid cycle.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) pulse_q <= '0;
        else
            for (int r = 0; r < NUM_REGS; r++)
                pulse_q[r] <= commit && widx == IW'(r) && |cstrb;
    end
    assign wr_pulse = pulse_q;
`endif
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb_axil_slave_regfile: randomized and directed checks of axil_slave_regfile against an array model.
module tb_axil_slave_regfile;
    logic        aclk = 0, areset_n = 0;
    logic [7:0]  awaddr = 0, araddr = 0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [511:0] reg_out;
`ifdef AXIL_SLV_WR_PULSE_EN
    logic [15:0] wr_pulse;
`endif
    logic [31:0] model [16];
    int n_checks = 0, n_pass = 0;

    axil_slave_regfile #(.ADDR_W(8), .NUM_REGS(16)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out)
`ifdef AXIL_SLV_WR_PULSE_EN
        , .wr_pulse(wr_pulse)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, reg_out[32*i +: 32], model[i]);
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[7:2]);
        if (idx < 16)
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // dly > 0: W leads AW by dly cycles; dly < 0: AW leads W; hold = cycles bready stays low
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int dly, input int hold);
        int idx = int'(a[7:2]);
        logic [1:0] exp_resp = idx < 16 ? 2'b00 : 2'b10;
        check("wr_idle_awready", awready, 1);
        check("wr_idle_wready", wready, 1);
        if (dly >= 0) begin wdata = d; wstrb = s; wvalid = 1; end
        if (dly <= 0) begin awaddr = a; awvalid = 1; end
        tick();
        if (dly > 0) begin
            wvalid = 0;
            check("wait_aw_wready", wready, 0);
            check("wait_aw_awready", awready, 1);
            repeat (dly - 1) begin check("wait_aw_bvalid", bvalid, 0); tick(); end
            awaddr = a; awvalid = 1;
            tick();
        end else if (dly < 0) begin
            awvalid = 0;
            check("wait_w_awready", awready, 0);
            check("wait_w_wready", wready, 1);
            repeat (-dly - 1) begin check("wait_w_bvalid", bvalid, 0); tick(); end
            wdata = d; wstrb = s; wvalid = 1;
            tick();
        end
        awvalid = 0; wvalid = 0;
        model_write(a, d, s);
        check("bvalid_rise", bvalid, 1);
        check("bresp", bresp, exp_resp);
`ifdef AXIL_SLV_WR_PULSE_EN
        check("wr_pulse", wr_pulse, (idx < 16 && s != 0) ? 32'(16'(1) << idx) : 0);
`endif
        repeat (hold) begin
            tick();
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
`ifdef AXIL_SLV_WR_PULSE_EN
            check("wr_pulse_clear", wr_pulse, 0);
`endif
        end
        bready = 1;
        tick();
        bready = 0;
        check("bvalid_fall", bvalid, 0);
        check_regs("reg_out");
    endtask

    task automatic rd(input logic [7:0] a, input int hold);
        int idx = int'(a[7:2]);
        logic [31:0] exp_d = idx < 16 ? model[idx] : 0;
        logic [1:0] exp_r = idx < 16 ? 2'b00 : 2'b10;
        check("rd_idle_arready", arready, 1);
        araddr = a; arvalid = 1;
        tick();
        arvalid = 0;
        check("rvalid_rise", rvalid, 1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        repeat (hold) begin
            tick();
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", rresp, exp_r);
            check("bp_arready", arready, 0);
        end
        rready = 1;
        tick();
        rready = 0;
        check("rvalid_fall", rvalid, 0);
    endtask

    initial begin
        logic [31:0] old, nd;
        for (int i = 0; i < 16; i++) model[i] = 0;
        repeat (3) tick();
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check_regs("rst_regs");
        areset_n = 1;
        tick();
        wr(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        check("reg1_direct", reg_out[63:32], 32'hDEADBEEF);
        rd(8'h04, 0);
        wr(8'h08, 32'h11223344, 4'hF, 3, 0);
        check("reg2_w_first", reg_out[95:64], 32'h11223344);
        wr(8'h08, 32'h0, 4'hF, 0, 0);
        wr(8'h08, 32'h11223344, 4'hF, -3, 0);
        check("reg2_aw_first", reg_out[95:64], 32'h11223344);
        wr(8'h08, 32'hAABBCCDD, 4'b0101, 0, 0);
        check("reg2_strobe", reg_out[95:64], 32'h11BB33DD);
        wr(8'h10, 32'hFFFFFFFF, 4'h0, 1, 1);
        wr(8'h40, 32'hCAFEF00D, 4'hF, 0, 0);
        rd(8'h40, 0);
        wr(8'h0E, 32'h55AA55AA, 4'hF, 0, 5);
        rd(8'h0C, 5);
        // simultaneous read and write to reg 5: read sees the pre-commit value
        old = model[5];
        nd = $urandom;
        awaddr = 8'h14; wdata = nd; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h14; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("same_edge_rdata", rdata, old);
        model_write(8'h14, nd, 4'hF);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        rd(8'h14, 0);
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a = 8'(($urandom_range(0, 23) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rd(a, $urandom_range(0, 3));
            else wr(a, $urandom, 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
        end
        // reset while both channels hold a response
        awaddr = 8'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h08; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("pre_rst_bvalid", bvalid, 1);
        check("pre_rst_rvalid", rvalid, 1);
        #2 areset_n = 0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = 0;
        check("async_rst_bvalid", bvalid, 0);
        check("async_rst_rvalid", rvalid, 0);
        check("async_rst_bresp", bresp, 0);
        check("async_rst_rdata", rdata, 0);
        check_regs("async_rst_regs");
        tick();
        areset_n = 1;
        tick();
        wr(8'h0C, 32'h0BADCAFE, 4'hF, 0, 2);
        rd(8'h0C, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
